// File: rtl/axis_rr_packet_arbiter_pkg.sv
// Shared types and helpers for the round-robin packet arbiter and its picker.
package axis_rr_packet_arbiter_pkg;

  localparam int PKT_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  function automatic int clogb2(input int unsigned value);
    int unsigned v;
    int          res;
    v   = value - 1;
    res = 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after last_grant, one-hot out.
// Zero latency; no flow control of its own.
module rr_pick
  import axis_rr_packet_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [clogb2(NUM_REQ)-1:0]  last_grant,
  output logic [NUM_REQ-1:0]          grant
);

  localparam int GW = clogb2(NUM_REQ);

  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-granular round-robin AXIS arbiter: 1-cycle arbitration bubble, then pass-through
// until TLAST; sink TREADY goes straight to the granted requester only.
module axis_rr_packet_arbiter
  import axis_rr_packet_arbiter_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_REQ              = 4,
  parameter int MAX_PKT_BEATS        = 1024
) (
  input  logic                                  S_AXIS_ACLK,
  input  logic                                  S_AXIS_ARESETN,
  input  logic [NUM_REQ-1:0]                    S_AXIS_TVALID,
  output logic [NUM_REQ-1:0]                    S_AXIS_TREADY,
  input  logic [NUM_REQ*C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [NUM_REQ*C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [NUM_REQ-1:0]                    S_AXIS_TLAST,
  output logic                                  M_AXIS_TVALID,
  input  logic                                  M_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]       M_AXIS_TDATA,
  output logic [C_S_AXIS_TDATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
  output logic                                  M_AXIS_TLAST,
  output logic [NUM_REQ-1:0]                    GRANT,
  output logic [NUM_REQ*PKT_CNT_W-1:0]          PKT_CNT,
  output logic [NUM_REQ-1:0]                    TRUNC_ERR
);

  localparam int W  = C_S_AXIS_TDATA_WIDTH;
  localparam int SW = W / 8;
  localparam int GW = clogb2(NUM_REQ);
  localparam int BW = (clogb2(MAX_PKT_BEATS) > 0) ? clogb2(MAX_PKT_BEATS) : 1;

  state_t                 state, state_nxt;
  logic [NUM_REQ-1:0]     grant_q, grant_nxt, pick;
  logic [GW-1:0]          gidx, gidx_nxt, last_grant, last_nxt, pick_idx;
  logic [BW-1:0]          beat_cnt, beat_nxt;
  logic [W-1:0]           dat_arr  [NUM_REQ];
  logic [SW-1:0]          strb_arr [NUM_REQ];
  logic [PKT_CNT_W-1:0]   pkt_cnt  [NUM_REQ];
  logic [NUM_REQ-1:0]     trunc_err;
  logic                   xfer, beat, done, wd_hit, trunc;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign dat_arr[i]                        = S_AXIS_TDATA[i*W +: W];
    assign strb_arr[i]                       = S_AXIS_TSTRB[i*SW +: SW];
    assign PKT_CNT[i*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt[i];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (S_AXIS_TVALID),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = GW'(i);
    end
  end

  // grant_q is only non-zero in XFER, so it doubles as the TREADY steering mask
  assign xfer          = (state == XFER);
  assign wd_hit        = (beat_cnt == BW'(MAX_PKT_BEATS - 1));
  assign M_AXIS_TVALID = xfer & S_AXIS_TVALID[gidx];
  assign M_AXIS_TDATA  = xfer ? dat_arr[gidx]  : '0;
  assign M_AXIS_TSTRB  = xfer ? strb_arr[gidx] : '0;
  assign M_AXIS_TLAST  = xfer & (S_AXIS_TLAST[gidx] | wd_hit);
  assign S_AXIS_TREADY = grant_q & {NUM_REQ{M_AXIS_TREADY}};
  assign GRANT         = grant_q;
  assign TRUNC_ERR     = trunc_err;

  assign beat  = M_AXIS_TVALID & M_AXIS_TREADY;
  assign done  = beat & M_AXIS_TLAST;
  assign trunc = done & ~S_AXIS_TLAST[gidx];

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    gidx_nxt  = gidx;
    last_nxt  = last_grant;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (|S_AXIS_TVALID) begin
          state_nxt = XFER;
          grant_nxt = pick;
          gidx_nxt  = pick_idx;
        end
      end
      XFER: begin
        if (done) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gidx;
          beat_nxt  = '0;
        end else if (beat) begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state      <= IDLE;
      grant_q    <= '0;
      gidx       <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_q    <= grant_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      for (int i = 0; i < NUM_REQ; i++) pkt_cnt[i] <= '0;
      trunc_err <= '0;
    end else begin
      if (done)  pkt_cnt[gidx]   <= pkt_cnt[gidx] + 1'b1;
      if (trunc) trunc_err[gidx] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: four queue-backed sources, beat/grant monitor.
module tb_axis_rr_packet_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = W / 8;
  localparam int MB = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     s_tvalid, s_tready, s_tlast;
  logic [N*W-1:0]   s_tdata;
  logic [N*SW-1:0]  s_tstrb;
  logic             m_tvalid, m_tready, m_tlast;
  logic [W-1:0]     m_tdata;
  logic [SW-1:0]    m_tstrb;
  logic [N-1:0]     grant, trunc_err;
  logic [N*16-1:0]  pkt_cnt;

  always #5 clk = ~clk;

  axis_rr_packet_arbiter #(
    .C_S_AXIS_TDATA_WIDTH(W), .NUM_REQ(N), .MAX_PKT_BEATS(MB)
  ) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(m_tdata),
    .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast),
    .GRANT(grant), .PKT_CNT(pkt_cnt), .TRUNC_ERR(trunc_err)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0]   smem [N][64];
  int           head [N];
  int           tail [N];
  logic [N-1:0] en;
  logic [W:0]   mon [$];
  logic [N-1:0] gtrace [$];
  logic [N-1:0] prev_grant;
  logic [3:0]   pat;
  int           pidx;
  logic         use_pat;
  int           tr_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_dat(input int i, input int k);
    return 32'hA000_0000 | (32'(i) << 20) | 32'(k);
  endfunction

  task automatic push_pkt(input int i, input int nbeats, input int last_at);
    for (int k = 1; k <= nbeats; k++) begin
      smem[i][tail[i]] = {(k == last_at), exp_dat(i, k)};
      tail[i]++;
    end
  endtask

  task automatic drive();
    logic       v;
    logic [W:0] e;
    for (int i = 0; i < N; i++) begin
      v = en[i] && (head[i] < tail[i]);
      e = v ? smem[i][head[i]] : '0;
      s_tvalid[i]          = v;
      s_tdata[i*W +: W]    = e[W-1:0];
      s_tlast[i]           = e[W];
      s_tstrb[i*SW +: SW]  = v ? (4'hF ^ 4'(i)) : 4'h0;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  // sample at negedge, retire handshaken source beats and redrive after posedge
  task automatic cycle();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) mon.push_back({m_tlast, m_tdata});
    if (grant != '0 && grant != prev_grant) gtrace.push_back(grant);
    prev_grant = grant;
    if ((s_tready & ~grant) != '0) tr_bad++;
    if (grant != '0 && ((|(s_tready & grant)) != m_tready)) tr_bad++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
    if (use_pat) begin
      m_tready = pat[pidx % 4];
      pidx++;
    end
    drive();
  endtask

  task automatic run_until_idle(input string tag);
    logic busy;
    busy = 1'b1;
    for (int c = 0; c < 200 && busy; c++) begin
      cycle();
      busy = (grant != '0);
      for (int i = 0; i < N; i++) if (en[i] && head[i] < tail[i]) busy = 1'b1;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    clear_src();
    en = '1;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_grant = '0;
    mon.delete();
    gtrace.delete();
    tr_bad = 0;
  endtask

  initial begin
    m_tready = 1'b1;
    use_pat = 1'b0;
    pat = 4'b1001;
    pidx = 0;
    tr_bad = 0;
    prev_grant = '0;
    en = '1;
    clear_src();
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0;

    // reset state with requester 0 already presenting a packet
    push_pkt(0, 4, 4);
    drive();
    @(posedge clk);
    #1;
    chk("rst_tready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_pktcnt", pkt_cnt, 0);
    chk("rst_trunc", trunc_err, 0);
    rst_n = 1'b1;

    // single 4-beat packet from requester 0
    chk("t1_arb_cycle", grant, 0);
    cycle();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_idle_nobeat", mon.size(), 0);
    chk("t1_strb", m_tstrb, 4'hF);
    repeat (4) cycle();
    chk("t1_nbeats", mon.size(), 4);
    for (int k = 0; k < 4; k++) chk("t1_beat", mon[k], {(k == 3), exp_dat(0, k + 1)});
    chk("t1_grant_off", grant, 0);
    chk("t1_pktcnt0", pkt_cnt[15:0], 1);

    // all four requesters, 3-beat packets; requester 0 has two
    reset_dut();
    for (int i = 0; i < N; i++) push_pkt(i, 3, 3);
    push_pkt(0, 3, 3);
    drive();
    repeat (4) cycle();
    chk("t2_beats_at4", mon.size(), 3);
    repeat (4) cycle();
    chk("t2_beats_at8", mon.size(), 6);
    run_until_idle("t2_drain");
    chk("t2_ngrants", gtrace.size(), 5);
    chk("t2_g0", gtrace[0], 4'b0001);
    chk("t2_g1", gtrace[1], 4'b0010);
    chk("t2_g2", gtrace[2], 4'b0100);
    chk("t2_g3", gtrace[3], 4'b1000);
    chk("t2_g4", gtrace[4], 4'b0001);
    chk("t2_nbeats", mon.size(), 15);
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 3; k++)
        chk("t2_beat", mon[p*3 + k], {(k == 2), exp_dat(p % 4, k + 1)});
    chk("t2_pktcnt", pkt_cnt, {16'd1, 16'd1, 16'd1, 16'd2});
    chk("t2_tready", tr_bad, 0);

    // sink backpressure while requester 2 sends 5 beats
    reset_dut();
    push_pkt(2, 5, 5);
    drive();
    use_pat = 1'b1;
    m_tready = pat[0];
    pidx = 1;
    cycle();
    chk("t3_grant", grant, 4'b0100);
    chk("t3_strb", m_tstrb, 4'hD);
    run_until_idle("t3_drain");
    use_pat = 1'b0;
    m_tready = 1'b1;
    chk("t3_nbeats", mon.size(), 5);
    for (int k = 0; k < 5; k++) chk("t3_beat", mon[k], {(k == 4), exp_dat(2, k + 1)});
    chk("t3_tready", tr_bad, 0);
    chk("t3_pktcnt2", pkt_cnt[47:32], 1);

    // watchdog: 10 beats from requester 1, TLAST only on beat 10
    reset_dut();
    push_pkt(1, 10, 10);
    drive();
    repeat (8) cycle();
    chk("t4_wd_force", m_tlast, 1'b1);
    chk("t4_trunc_pre", trunc_err, 0);
    cycle();
    chk("t4_pktcnt_a", pkt_cnt[31:16], 1);
    chk("t4_trunc", trunc_err, 4'b0010);
    chk("t4_grant_off", grant, 0);
    chk("t4_nbeats_a", mon.size(), 8);
    chk("t4_beat8", mon[7], {1'b1, exp_dat(1, 8)});
    run_until_idle("t4_drain");
    chk("t4_pktcnt_b", pkt_cnt[31:16], 2);
    chk("t4_nbeats_b", mon.size(), 10);
    chk("t4_beat9", mon[8], {1'b0, exp_dat(1, 9)});
    chk("t4_beat10", mon[9], {1'b1, exp_dat(1, 10)});
    chk("t4_trunc_sticky", trunc_err, 4'b0010);

    // grant hold while requester 3 stalls; requester 0 waits
    reset_dut();
    en = 4'b1000;
    push_pkt(3, 4, 4);
    push_pkt(0, 2, 2);
    drive();
    cycle();
    chk("t5_grant", grant, 4'b1000);
    en = '1;
    drive();
    repeat (2) cycle();
    en[3] = 1'b0;
    drive();
    begin
      int hold_bad;
      hold_bad = 0;
      repeat (5) begin
        cycle();
        if (grant != 4'b1000) hold_bad++;
      end
      chk("t5_hold", hold_bad, 0);
    end
    chk("t5_stall_beats", mon.size(), 2);
    en[3] = 1'b1;
    drive();
    run_until_idle("t5_drain");
    chk("t5_ngrants", gtrace.size(), 2);
    chk("t5_g0", gtrace[0], 4'b1000);
    chk("t5_g1", gtrace[1], 4'b0001);
    chk("t5_beat4", mon[3], {1'b1, exp_dat(3, 4)});
    chk("t5_beat5", mon[4], {1'b0, exp_dat(0, 1)});
    chk("t5_tready", tr_bad, 0);

    // reset pulsed mid-packet from requester 2
    push_pkt(2, 6, 6);
    drive();
    repeat (3) cycle();
    chk("t6_pre_grant", grant, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t6_tready", s_tready, 0);
    chk("t6_mvalid", m_tvalid, 0);
    chk("t6_grant", grant, 0);
    chk("t6_pktcnt", pkt_cnt, 0);
    @(posedge clk);
    #1;
    clear_src();
    push_pkt(1, 2, 2);
    push_pkt(0, 2, 2);
    rst_n = 1'b1;
    drive();
    prev_grant = '0;
    mon.delete();
    gtrace.delete();
    run_until_idle("t6_drain");
    chk("t6_g0", gtrace[0], 4'b0001);
    chk("t6_g1", gtrace[1], 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
Shares one AXI4-Stream sink (the FIFO-backed stream receiver) between NUM_REQ upstream stream masters. Arbitration is round-robin and packet-granular: a grant is held from the first beat to the TLAST beat. A beat-limit watchdog truncates runaway packets. Per-requester packet counters are provided for the bench and for status registers.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, data width of every stream (multiple of 8).
NUM_REQ, 4, number of upstream requesters (2..8).
MAX_PKT_BEATS, 1024, beat limit per packet; the limit beat is forced to carry TLAST.

Ports:
S_AXIS_ACLK  input  1  single clock for all logic.
S_AXIS_ARESETN  input  1  asynchronous, active-low reset.
S_AXIS_TVALID  input  NUM_REQ  per-requester valid.
S_AXIS_TREADY  output  NUM_REQ  per-requester ready.
S_AXIS_TDATA  input  NUM_REQ*C_S_AXIS_TDATA_WIDTH  flattened data; requester i occupies slice i.
S_AXIS_TSTRB  input  NUM_REQ*C_S_AXIS_TDATA_WIDTH/8  flattened byte qualifiers.
S_AXIS_TLAST  input  NUM_REQ  per-requester end of packet.
M_AXIS_TVALID  output  1  to the shared sink.
M_AXIS_TREADY  input  1  from the shared sink.
M_AXIS_TDATA  output  C_S_AXIS_TDATA_WIDTH  muxed data.
M_AXIS_TSTRB  output  C_S_AXIS_TDATA_WIDTH/8  muxed strobes.
M_AXIS_TLAST  output  1  muxed TLAST, OR'd with the watchdog truncate.
GRANT  output  NUM_REQ  one-hot current grant; 0 when idle.
PKT_CNT  output  NUM_REQ*16  per-requester count of completed packets; wraps at 16 bits.
TRUNC_ERR  output  NUM_REQ  sticky per-requester flag: a packet was truncated by the watchdog.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the user):
  - state=IDLE; GRANT=0; last_grant=NUM_REQ-1, so requester 0 wins first.
  - beat_cnt=0; PKT_CNT=0; TRUNC_ERR=0.
  - All TREADY=0 and M_AXIS_TVALID=0 immediately.
- States:
  - IDLE: no grant and all outputs quiet. If any TVALID is high, register GRANT as the first requester with TVALID high, scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. Go to XFER. Arbitration latency is 1 cycle, and no beat transfers in the IDLE cycle.
  - XFER: combinational pass-through from the granted slice g.
    - M_AXIS_TVALID=S_AXIS_TVALID[g]; M_AXIS_TDATA, M_AXIS_TSTRB and M_AXIS_TLAST come from slice g.
    - S_AXIS_TREADY[g]=M_AXIS_TREADY; all other TREADY bits are 0.
    - A beat is a cycle with M_AXIS_TVALID && M_AXIS_TREADY; each beat increments beat_cnt.
    - On a beat with effective TLAST: PKT_CNT[g]++, last_grant=g, beat_cnt=0, GRANT=0, go to IDLE.
- Watchdog:
  - When beat_cnt==MAX_PKT_BEATS-1 and the current beat has no TLAST, force M_AXIS_TLAST=1 on that beat.
  - Set TRUNC_ERR[g] and end the packet exactly as above.
  - The remaining beats of that packet are then arbitrated as a new packet.
- Grant hold: the grant is held while the granted TVALID is low mid-packet; there is no re-arbitration until TLAST.
- One bubble cycle (IDLE) separates consecutive packets, even from the same requester. Sustained throughput is N/(N+1) for N-beat packets.
- Fairness: a requester waits at most NUM_REQ-1 packets before its grant.
- Single requester active: it is granted every packet.
- Requesters asserting TVALID while not granted see TREADY=0 and must hold their data (AXIS rule); the arbiter never drops a beat.
- A reset asserted mid-packet abandons the packet; the sink must also be reset.
- Widths: beat_cnt is clogb2(MAX_PKT_BEATS) bits; PKT_CNT is modulo 2^16.

Decomposition:
- Shared package/header: clogb2 function; state encodings IDLE=1'b0 and XFER=1'b1; PKT_CNT_W=16.
- Sub-module rr_pick: combinational round-robin priority selector with inputs req[NUM_REQ] and last_grant, output one-hot grant. It is reusable by other schedulers.
- The mux, FSM, watchdog and counters stay in the top module.

Test Plan:
- Single requester 0 sends a 4-beat packet, M_AXIS_TREADY=1 → GRANT=4'b0001 one cycle after TVALID; 4 consecutive beats; TLAST on beat 4; PKT_CNT[0]=1; GRANT=0 on the next cycle.
- Requesters 0..3 all send 3-beat packets, held continuously → grant order 0,1,2,3,0; one idle cycle between packets; data matches per-requester patterns 0xA0i0_000k.
- Sink applies backpressure: M_AXIS_TREADY toggles 1-0-0-1 while requester 2 sends 5 beats → 5 beats delivered in order; TREADY[2] mirrors M_AXIS_TREADY; other TREADY bits stay 0.
- MAX_PKT_BEATS=8; requester 1 sends 10 beats without TLAST → beat 8 is output with TLAST=1; TRUNC_ERR[1]=1; the next 2 beats form a new packet after re-arbitration; PKT_CNT[1]=1 then 2 once TLAST arrives.
- Requester 3 drops TVALID for 5 cycles mid-packet while requester 0 is valid → GRANT stays 4'b1000 until requester 3's TLAST; requester 0 is granted next.
- S_AXIS_ARESETN pulsed low mid-packet → all TREADY, M_AXIS_TVALID, GRANT and PKT_CNT are 0 within the same cycle; after release, requester 0 wins first.
